// File: rtl/i1_po_monitor.sv
// i1_po_monitor: samples the 16-bit po vector and detects bit changes.
// Each change (and the first sample after reset) becomes an event
// {word, mask, seq}. Events are queued in a small first-word-fall-through
// FIFO and handed to a consumer over valid/ready. Events that arrive while
// the FIFO is full and not being drained are dropped and counted.
module i1_po_monitor #(
    parameter int DEPTH = 4,
    parameter int SEQ_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [15:0]              in_po,
    input  logic                     out_ready,
    input  logic                     clr_ovf,
    output logic                     out_valid,
    output logic [15:0]              out_word,
    output logic [15:0]              out_mask,
    output logic [SEQ_W-1:0]         out_seq,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     ovf,
    output logic [SEQ_W-1:0]         drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;
    localparam logic [OW-1:0] FULL_OCC = OW'(DEPTH);

    // Saturating increment for the drop counter: holds at all-ones.
    function automatic logic [SEQ_W-1:0] sat_inc(input logic [SEQ_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Change-detector state
    logic [15:0]      r_last;
    logic             r_first;
    logic [SEQ_W-1:0] r_seq;

    // FIFO control and storage
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [OW-1:0]    r_occ;
    logic [15:0]      r_word_mem [DEPTH];
    logic [15:0]      r_mask_mem [DEPTH];
    logic [SEQ_W-1:0] r_seq_mem  [DEPTH];

    // Overflow bookkeeping
    logic             r_ovf;
    logic [SEQ_W-1:0] r_drop;

    logic [15:0] w_diff;
    logic        w_event;
    logic        w_full;
    logic        w_empty;
    logic        w_pop;
    logic        w_push;
    logic        w_drop;

    // Event detection and FIFO handshake decode.
    always_comb begin
        w_diff  = in_po ^ r_last;
        w_event = in_valid & (r_first | (w_diff != 16'h0000));
        w_full  = (r_occ == FULL_OCC);
        w_empty = (r_occ == '0);
        // A full FIFO that is being popped this cycle can still accept the
        // new event (replace-through); only a full, stalled FIFO drops.
        w_pop   = ~w_empty & out_ready;
        w_push  = w_event & (~w_full | w_pop);
        w_drop  = w_event & w_full & ~w_pop;
    end

    // Control state: detector, pointers, occupancy and overflow tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last  <= '0;
            r_first <= 1'b1;
            r_seq   <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_occ   <= '0;
            r_ovf   <= 1'b0;
            r_drop  <= '0;
        end else begin
            if (in_valid) begin
                r_last  <= in_po;
                r_first <= 1'b0;
            end
            // Sequence advances on every event, dropped or not, so gaps
            // seen by the consumer reveal lost events.
            if (w_event) begin
                r_seq <= r_seq + 1'b1;
            end
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_occ <= r_occ + 1'b1;
            end else if (w_pop && !w_push) begin
                r_occ <= r_occ - 1'b1;
            end
            // A drop in the same cycle as a clear wins over the clear.
            if (clr_ovf) begin
                r_ovf  <= w_drop;
                r_drop <= w_drop ? SEQ_W'(1) : '0;
            end else if (w_drop) begin
                r_ovf  <= 1'b1;
                r_drop <= sat_inc(r_drop);
            end
        end
    end

    // Event payload storage; contents are only meaningful below occupancy.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_word_mem[r_wptr] <= in_po;
            r_mask_mem[r_wptr] <= w_diff;
            r_seq_mem[r_wptr]  <= r_seq;
        end
    end

    assign out_valid = ~w_empty;
    assign out_word  = r_word_mem[r_rptr];
    assign out_mask  = r_mask_mem[r_rptr];
    assign out_seq   = r_seq_mem[r_rptr];
    assign occupancy = r_occ;
    assign ovf       = r_ovf;
    assign drop_cnt  = r_drop;

endmodule

// File: tb/tb_i1_po_monitor.sv
// Testbench for i1_po_monitor: a scoreboard queue holds the expected events
// and the bench's own model of occupancy, ovf and drop count.
module tb_i1_po_monitor;

    localparam int DEPTH = 4;
    localparam int SEQ_W = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_po = 16'h0000;
    logic        out_ready = 1'b0;
    logic        clr_ovf = 1'b0;
    logic        out_valid;
    logic [15:0] out_word;
    logic [15:0] out_mask;
    logic [7:0]  out_seq;
    logic [2:0]  occupancy;
    logic        ovf;
    logic [7:0]  drop_cnt;

    i1_po_monitor #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_po(in_po),
        .out_ready(out_ready), .clr_ovf(clr_ovf), .out_valid(out_valid),
        .out_word(out_word), .out_mask(out_mask), .out_seq(out_seq),
        .occupancy(occupancy), .ovf(ovf), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] w;
        logic [15:0] m;
        logic [7:0]  s;
    } ev_t;

    ev_t         m_q[$];
    logic [15:0] m_last;
    bit          m_first;
    logic [7:0]  m_seq;
    bit          m_ovf;
    int          m_drop;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        m_last  = 16'h0000;
        m_first = 1'b1;
        m_seq   = 8'h00;
        m_ovf   = 1'b0;
        m_drop  = 0;
    endtask

    // Reset for one edge with junk on the data inputs, which must be ignored.
    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b1; in_po = 16'hFFFF; out_ready = 1'b1; clr_ovf = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; in_po = 16'h0000; out_ready = 1'b0;
        model_clear();
        check("rst_valid", out_valid, 0);
        check("rst_occ", occupancy, 0);
        check("rst_ovf", ovf, 0);
        check("rst_drop", drop_cnt, 0);
    endtask

    // Drive one cycle; compare the presented head with the scoreboard,
    // update the model, then check the registered status after the edge.
    task automatic cycle(input logic v, input logic [15:0] po, input logic rdy, input logic clr);
        bit          full, pop, evt;
        logic [15:0] d;
        ev_t         e;
        in_valid = v; in_po = po; out_ready = rdy; clr_ovf = clr;
        if (m_q.size() > 0) begin
            check("head_word", out_word, m_q[0].w);
            check("head_mask", out_mask, m_q[0].m);
            check("head_seq", out_seq, m_q[0].s);
        end
        full = (m_q.size() == DEPTH);
        pop  = (m_q.size() != 0) && rdy;
        d    = po ^ m_last;
        evt  = v && (m_first || d != 16'h0000);
        if (clr) begin
            m_ovf = 1'b0;
            m_drop = 0;
        end
        if (pop) m_q.delete(0);
        if (evt) begin
            if (!full || pop) begin
                e.w = po; e.m = d; e.s = m_seq;
                m_q.push_back(e);
            end else begin
                m_ovf = 1'b1;
                if (m_drop < 255) m_drop = m_drop + 1;
            end
            m_seq = m_seq + 8'd1;
        end
        if (v) begin
            m_last = po;
            m_first = 1'b0;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
        check("occ", occupancy, m_q.size());
        check("valid", out_valid, m_q.size() != 0);
        check("ovf", ovf, m_ovf);
        check("drop", drop_cnt, m_drop);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    endtask

    initial begin
        model_clear();
        @(negedge clk);
        do_reset();

        // First sample of zero still produces an event.
        cycle(1'b1, 16'h0000, 1'b0, 1'b0);
        check("r032_valid", out_valid, 1);
        check("r032_word", out_word, 16'h0000);
        check("r032_mask", out_mask, 16'h0000);
        check("r032_seq", out_seq, 0);
        drain();

        // Repeated sample produces no event.
        do_reset();
        cycle(1'b1, 16'h0001, 1'b0, 1'b0);
        cycle(1'b1, 16'h0001, 1'b0, 1'b0);
        cycle(1'b1, 16'h8001, 1'b0, 1'b0);
        check("r033_occ", occupancy, 2);
        check("r033_w0", out_word, 16'h0001);
        check("r033_m0", out_mask, 16'h0001);
        check("r033_s0", out_seq, 0);
        cycle(1'b0, 16'h0000, 1'b1, 1'b0);
        check("r033_w1", out_word, 16'h8001);
        check("r033_m1", out_mask, 16'h8000);
        check("r033_s1", out_seq, 1);
        drain();

        // Overflow: six events into a four-entry FIFO.
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1'b1, (i % 2 == 0) ? 16'h0001 : 16'h0002, 1'b0, 1'b0);
        check("r034_occ", occupancy, 4);
        check("r034_ovf", ovf, 1);
        check("r034_drop", drop_cnt, 2);
        for (int i = 0; i < 4; i++) begin
            check("r034_drain_seq", out_seq, i);
            cycle(1'b0, 16'h0000, 1'b1, 1'b0);
        end
        check("r034_empty", out_valid, 0);

        // Refill, then push and pop together while full.
        for (int i = 0; i < 4; i++) cycle(1'b1, (i % 2 == 0) ? 16'h0001 : 16'h0002, 1'b0, 1'b0);
        cycle(1'b1, 16'h0004, 1'b1, 1'b0);
        check("r035_occ", occupancy, 4);
        check("r035_ovf", ovf, 1);
        check("r035_drop", drop_cnt, 2);

        // Clear coinciding with a drop, then clear alone.
        cycle(1'b1, 16'h0008, 1'b0, 1'b1);
        check("r036_ovf", ovf, 1);
        check("r036_drop", drop_cnt, 1);
        cycle(1'b0, 16'h0000, 1'b0, 1'b1);
        check("r036_clr_ovf", ovf, 0);
        check("r036_clr_drop", drop_cnt, 0);
        drain();

        // Drop counter saturation and sequence wrap.
        do_reset();
        for (int i = 0; i < 304; i++) cycle(1'b1, (i % 2 == 0) ? 16'h0001 : 16'h0002, 1'b0, 1'b0);
        check("sat_drop", drop_cnt, 255);
        cycle(1'b0, 16'h0000, 1'b0, 1'b1);
        drain();
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'h00F0 + 16'(i), 1'b0, 1'b0);

        // Mixed random traffic.
        for (int i = 0; i < 400; i++) begin
            logic [15:0] p;
            case ($urandom_range(0, 3))
                0: p = 16'h0000;
                1: p = 16'h0001;
                2: p = 16'h8000;
                default: p = 16'($urandom);
            endcase
            cycle(1'($urandom_range(0, 1)), p, 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 15) == 0));
        end

        // Reset with events queued discards them; next sample is first.
        drain();
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'h0010 << i, 1'b0, 1'b0);
        check("r037_pre_occ", occupancy, 3);
        do_reset();
        check("r037_valid", out_valid, 0);
        cycle(1'b1, 16'h0000, 1'b0, 1'b0);
        check("r037_seq", out_seq, 0);
        check("r037_mask", out_mask, 16'h0000);
        check("r037_occ", occupancy, 1);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/i1_po_monitor.md
I1_PO_MONITOR -- requirements
Module: i1_po_monitor

Purpose: downstream stage of the i1 decode logic. Samples the 16-bit po vector, detects bit changes, and queues change events with sequence numbers for a consumer using valid/ready.

Interface
REQ-001 Parameter DEPTH, default 4: number of event FIFO entries; must be a power of 2 and at least 2.
REQ-002 Parameter SEQ_W, default 8: width of the event sequence counter and the drop counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 in_valid  input  1  in_po is a valid sample this cycle; always accepted, no backpressure.
REQ-006 in_po  input  16  po00..po15 of the upstream stage, bit k = pok.
REQ-007 out_ready  input  1  consumer accepts the head event this cycle.
REQ-008 clr_ovf  input  1  clears ovf and drop_cnt.
REQ-009 out_valid  output  1  FIFO non-empty; head event presented.
REQ-010 out_word  output  16  po sample of the head event.
REQ-011 out_mask  output  16  changed-bit mask of the head event.
REQ-012 out_seq  output  SEQ_W  sequence number of the head event.
REQ-013 occupancy  output  clog2(DEPTH)+1  number of FIFO entries, 0..DEPTH.
REQ-014 ovf  output  1  sticky flag: at least one event was dropped.
REQ-015 drop_cnt  output  SEQ_W  number of dropped events, saturating.

Function
REQ-016 Block holds last (16b, last accepted sample) and first (1b, set after reset).
REQ-017 On in_valid: diff = in_po XOR last; event = first OR (diff != 0); last <= in_po; first <= 0.
REQ-018 Event payload {word=in_po, mask=diff, seq=seq_ctr}; for the first sample last = 0, so mask = in_po; the first sample always generates an event, even when in_po = 0.
REQ-019 seq_ctr increments by 1 on every event, including dropped events, so seq gaps expose drops; wraps from 2^SEQ_W-1 to 0.
REQ-020 Push = event AND (occupancy < DEPTH OR pop). Pop = out_valid AND out_ready.
REQ-021 Simultaneous push and pop: both take effect and occupancy is unchanged; this applies when full (replace-through) and is legal when empty only if push happens first (pop requires out_valid=1).
REQ-022 Drop = event AND occupancy = DEPTH AND NOT pop: the FIFO is unchanged, ovf <= 1, and drop_cnt increments, saturating at 2^SEQ_W-1.
REQ-023 clr_ovf: ovf <= 0 and drop_cnt <= 0; on a drop in the same cycle, ovf <= 1 and drop_cnt <= 1.
REQ-024 FIFO is first-word-fall-through; out_word, out_mask and out_seq are driven from head storage.
REQ-025 Latency: an event accepted at edge N appears at the outputs after edge N and is consumable in cycle N+1.
REQ-026 Output values are don't-care when out_valid=0, but the head payload must stay stable while out_valid=1 and out_ready=0.
REQ-027 Pointers are clog2(DEPTH) bits and wrap modulo DEPTH; full and empty are derived from occupancy.
REQ-028 When in_valid=0: last, first, seq_ctr and drop logic are unchanged; pop still operates.

Reset
REQ-029 While rst=1 at an edge, all other inputs are ignored that cycle.
REQ-030 Reset values: occupancy=0, out_valid=0, ovf=0, drop_cnt=0, seq_ctr=0, last=0, first=1, pointers=0.
REQ-031 Reset mid-operation discards all queued events; the next sample after reset is treated as the first sample.

Verification
REQ-032 Reset, then in_valid with in_po=0x0000 -> next cycle out_valid=1, word=0x0000, mask=0x0000, seq=0.
REQ-033 Samples 0x0001, 0x0001, 0x8001 with out_ready=0 -> two events: (0x0001, 0x0001, seq 0) and (0x8001, 0x8000, seq 1); occupancy=2.
REQ-034 DEPTH=4, out_ready=0, six toggling samples -> occupancy=4, events with seq 0..3 held, ovf=1, drop_cnt=2; draining yields seq 0,1,2,3.
REQ-035 Full FIFO, event with out_ready=1 in the same cycle -> pop and push both occur, occupancy stays 4, ovf unchanged.
REQ-036 With ovf=1, assert clr_ovf with a drop in the same cycle -> ovf=1, drop_cnt=1; clr_ovf alone -> ovf=0, drop_cnt=0.
REQ-037 rst with 3 events queued -> out_valid=0 next cycle; the next sample 0x0000 produces an event with seq=0.
